pc_register: RTL and testbench

//   Program-counter state register for the single-cycle RV32I core.

---
 rtl/pc_register.sv | 33 +++
 tb/tb_pc_register.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pc_register.sv
// rtl/pc_register.sv - RV32I program-counter register with pc+4 and optional alignment flag (PC_ALIGN_CHECK_EN)
module pc_register #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pcnext,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pc_misaligned
);

    localparam logic [WIDTH-1:0] INSN_BYTES = WIDTH'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pcnext;
        end
    end

    // Derived only from the registered pc, so pcnext never reaches these outputs combinationally.
    assign pc_plus4 = pc + INSN_BYTES;

`ifdef PC_ALIGN_CHECK_EN
    assign pc_misaligned = |pc[1:0];
`else
    assign pc_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_pc_register.sv
// tb/tb_pc_register.sv - randomized self-checking bench for pc_register against a last-loaded-value model
module tb_pc_register;

    localparam logic [31:0] RV_ALT = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcnext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_misaligned;

    logic        rst2;
    logic [31:0] pcnext2;
    logic [31:0] pc2;
    logic [31:0] pc2_plus4;
    logic        pc2_misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    pc_register #(.WIDTH(32), .RESET_VECTOR(32'h0)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .pcnext        (pcnext),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .pc_misaligned (pc_misaligned)
    );

    pc_register #(.WIDTH(32), .RESET_VECTOR(RV_ALT)) u_dut_rv (
        .clk           (clk),
        .rst           (rst2),
        .pcnext        (pcnext2),
        .pc            (pc2),
        .pc_plus4      (pc2_plus4),
        .pc_misaligned (pc2_misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: an instruction address is misaligned when it is not a multiple of 4.
    function automatic logic [31:0] exp_mis(input logic [31:0] addr);
`ifdef PC_ALIGN_CHECK_EN
        return ((addr % 4) != 0) ? 32'd1 : 32'd0;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_main(input string tag, input logic [31:0] exp_pc);
        logic [31:0] nxt;
        nxt = exp_pc + 32'd4;
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".plus4"}, pc_plus4, nxt);
        check({tag, ".mis"}, {31'd0, pc_misaligned}, exp_mis(exp_pc));
    endtask

    task automatic check_alt(input string tag, input logic [31:0] exp_pc);
        logic [31:0] nxt;
        nxt = exp_pc + 32'd4;
        check({tag, ".pc"}, pc2, exp_pc);
        check({tag, ".plus4"}, pc2_plus4, nxt);
        check({tag, ".mis"}, {31'd0, pc2_misaligned}, exp_mis(exp_pc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] vals [4];
        logic [31:0] exp_pc;
        logic [31:0] prev;
        bit          keep_rst;

        vals[0] = 32'd0; vals[1] = 32'd4; vals[2] = 32'd8; vals[3] = 32'd12;
        rst = 1'b1; rst2 = 1'b1; pcnext = 32'd0; pcnext2 = 32'd0;

        // Reset applies before any clock edge.
        #2;
        check_main("reset_async", 32'd0);
        check_alt("alt_reset", RV_ALT);
        tick();
        check_main("reset_hold", 32'd0);
        #2 rst = 1'b0; rst2 = 1'b0;

        // Sequential loading: pc follows pcnext one edge later, pcnext alone does not move pc.
        prev = 32'd0;
        for (int i = 0; i < 4; i++) begin
            pcnext = vals[i];
            #1;
            check("no_comb_path", pc, prev);
            tick();
            check_main("seq_load", vals[i]);
            prev = vals[i];
            #1;
        end

        // Mid-cycle reset takes effect immediately and holds across edges.
        rst = 1'b1;
        #1;
        check_main("midcycle_reset", 32'd0);
        pcnext = 32'd12;
        tick();
        check_main("reset_edge1", 32'd0);
        tick();
        check_main("reset_edge2", 32'd0);

        // Release between edges: first edge loads pcnext.
        #2 rst = 1'b0;
        tick();
        check_main("release_load", 32'd12);
        #2 pcnext = 32'd100;
        tick();
        check_main("load_100", 32'd100);

        #2 pcnext = 32'hFFFF_FFFC;
        tick();
        check_main("wrap", 32'hFFFF_FFFC);

        #2 pcnext = 32'h6;
        tick();
        check_main("misaligned_6", 32'h6);
        #2 pcnext = 32'h8;
        tick();
        check_main("aligned_8", 32'h8);

        // Non-zero reset vector instance.
        #2 pcnext2 = 32'h1234;
        tick();
        check_alt("alt_load", 32'h1234);
        #2 rst2 = 1'b1;
        #1;
        check_alt("alt_pulse", RV_ALT);
        #1 rst2 = 1'b0;
        tick();
        check_alt("alt_release", 32'h1234);

        // Randomized traffic with occasional reset pulses.
        keep_rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (keep_rst) begin
                rst = 1'b0;
                keep_rst = 1'b0;
            end
            pcnext = $urandom;
            if ($urandom_range(0, 1) == 0) pcnext = pcnext & ~32'd3;
            pcnext2 = $urandom;
            exp_pc = pcnext;
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                #1;
                check_main("rand_async", 32'd0);
                if ($urandom_range(0, 1) == 0) begin
                    keep_rst = 1'b1;
                    exp_pc = 32'd0;
                end else begin
                    #1 rst = 1'b0;
                end
            end
            tick();
            check_main("rand", exp_pc);
            check_alt("rand_alt", pcnext2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
